display_writer: RTL and testbench
=================================

DISPLAY_WRITER -- requirements
Module: display_writer

Interface
REQ-001 Parameter COLS, default 80, characters per display row.
REQ-002 Parameter ROWS, default 32, display rows; COLS*ROWS = 2560 memory cells.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 char_in  input  8  ASCII character or control code.
REQ-006 char_vld  input  1  char_in valid.
REQ-007 char_rdy  output  1  block accepts char_in; transfer occurs when char_vld & char_rdy at a rising edge.
REQ-008 clr_req  input  1  request to blank the whole display.
REQ-009 busy  output  1  high while a clear sweep is in progress.
REQ-010 mem_we  output  1  display memory write enable, one cycle per write.
REQ-011 mem_addr  output  12  display memory write address, 0..2559.
REQ-012 mem_wd  output  8  display memory write data.
REQ-013 cur_x  output  7  cursor column, 0..COLS-1.
REQ-014 cur_y  output  5  cursor row, 0..ROWS-1.

Function
REQ-015 FSM states IDLE and CLEAR; the block SHALL be in IDLE after reset.
REQ-016 char_rdy SHALL equal (state==IDLE) & ~clr_req, combinationally.
REQ-017 In IDLE, clr_req=1 SHALL move to CLEAR on the next edge; clr_req beats char_vld in the same cycle, and that character is not consumed.
REQ-018 Printable character (0x20..0x7E) accepted: on the next cycle, mem_we=1, mem_addr=cur_y*COLS+cur_x (values before the update), mem_wd=char_in.
REQ-019 After a printable character, cur_x SHALL increment; if cur_x was COLS-1, cur_x becomes 0 and cur_y advances.
REQ-020 0x0A (LF) accepted: cur_x=0, cur_y advances, no write.
REQ-021 0x0D (CR) accepted: cur_x=0, cur_y unchanged, no write.
REQ-022 0x08 (BS) accepted: cur_x decrements if nonzero, else unchanged; no write, no row change.
REQ-023 Any other code accepted SHALL be consumed with no write and no cursor change.
REQ-024 cur_y advance SHALL wrap from ROWS-1 to 0; no scrolling.
REQ-025 Address SHALL come from a row-base register kept equal to cur_y*COLS and updated by +COLS, or to 0 on wrap; no multiplier.
REQ-026 CLEAR: busy=1, char_rdy=0, mem_we=1 every cycle, mem_wd=0x20, mem_addr stepping 0,1,...,COLS*ROWS-1 on consecutive cycles.
REQ-027 After address COLS*ROWS-1 is written, the next edge SHALL return to IDLE with cur_x=0, cur_y=0, and row base 0; a clear takes exactly COLS*ROWS write cycles.
REQ-028 clr_req during CLEAR SHALL be ignored, with no restart and no queuing.
REQ-029 mem_we, mem_addr, and mem_wd SHALL be registered outputs; mem_we=0 in every cycle without a write.
REQ-030 Throughput SHALL be one character per cycle in IDLE with no bubbles.

Reset
REQ-031 rst=1 at an edge SHALL set state=IDLE, busy=0, mem_we=0, mem_addr=0, mem_wd=0, cur_x=0, cur_y=0, and row base 0.
REQ-032 rst asserted mid-CLEAR SHALL abort the sweep immediately; memory cells not yet written keep their old contents.
REQ-033 A character presented in the reset cycle SHALL be discarded; char_rdy is 1 in the first cycle after reset deasserts when clr_req=0.

Verification
REQ-034 After reset, send 'A' (0x41) -> next cycle mem_we=1, addr=0, wd=0x41; then cur_x=1, cur_y=0.
REQ-035 Cursor at (79,0), send 0x42 -> write at addr 79; then cur_x=0, cur_y=1; next 0x43 writes at addr 80.
REQ-036 Cursor at (5,31), send 0x0A -> no write; cursor (0,0). Then 0x0D, 0x08 at (0,0) -> cursor stays (0,0), mem_we never 1.
REQ-037 Pulse clr_req -> busy high 2560 cycles, writes 0x20 to addr 0..2559 in order, char_rdy=0 throughout, then cursor (0,0) and char_rdy=1.
REQ-038 clr_req and char_vld=1 with 0x41 in the same cycle -> no 'A' write; the sweep starts; 0x41 is accepted after the sweep if still held.
REQ-039 rst at sweep address 1000 -> mem_we=0 next cycle; addr 1000..2559 not written; state IDLE.

Source files
------------

// File: rtl/display_writer.sv
// Character-stream display writer: turns a byte stream into display-memory writes
// at a wrapping cursor, and sweeps the whole memory to blanks on a clear request.
module display_writer #(
    parameter int unsigned COLS = 80,
    parameter int unsigned ROWS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  char_in,
    input  logic        char_vld,
    output logic        char_rdy,
    input  logic        clr_req,
    output logic        busy,
    output logic        mem_we,
    output logic [11:0] mem_addr,
    output logic [7:0]  mem_wd,
    output logic [6:0]  cur_x,
    output logic [4:0]  cur_y
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;

    localparam logic [6:0]  LAST_X    = 7'(COLS - 1);
    localparam logic [4:0]  LAST_Y    = 5'(ROWS - 1);
    localparam logic [11:0] LAST_ADDR = 12'(COLS * ROWS - 1);
    localparam logic [11:0] ROW_STEP  = 12'(COLS);

    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_TILDE = 8'h7E;

    logic [0:0]  state_q,    state_d;
    logic [6:0]  cur_x_q,    cur_x_d;
    logic [4:0]  cur_y_q,    cur_y_d;
    logic [11:0] row_base_q, row_base_d;
    logic        mem_we_q,   mem_we_d;
    logic [11:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_wd_q,   mem_wd_d;

    logic accept;
    logic printable;
    logic adv_row;

    assign char_rdy  = (state_q == IDLE) & ~clr_req;
    assign accept    = char_vld & char_rdy;
    assign printable = (char_in >= CH_SPACE) && (char_in <= CH_TILDE);

    always_comb begin
        state_d    = state_q;
        cur_x_d    = cur_x_q;
        cur_y_d    = cur_y_q;
        row_base_d = row_base_q;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_wd_d   = mem_wd_q;
        adv_row    = 1'b0;

        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d    = CLEAR;
                    mem_we_d   = 1'b1;
                    mem_addr_d = '0;
                    mem_wd_d   = CH_SPACE;
                end else if (accept) begin
                    if (printable) begin
                        mem_we_d   = 1'b1;
                        mem_addr_d = row_base_q + {5'b0, cur_x_q};
                        mem_wd_d   = char_in;
                        if (cur_x_q == LAST_X) begin
                            cur_x_d = '0;
                            adv_row = 1'b1;
                        end else begin
                            cur_x_d = cur_x_q + 7'd1;
                        end
                    end else if (char_in == CH_LF) begin
                        cur_x_d = '0;
                        adv_row = 1'b1;
                    end else if (char_in == CH_CR) begin
                        cur_x_d = '0;
                    end else if (char_in == CH_BS) begin
                        if (cur_x_q != '0) begin
                            cur_x_d = cur_x_q - 7'd1;
                        end
                    end
                end
            end
            CLEAR: begin
                // The registered address doubles as the sweep counter.
                if (mem_addr_q == LAST_ADDR) begin
                    state_d    = IDLE;
                    cur_x_d    = '0;
                    cur_y_d    = '0;
                    row_base_d = '0;
                end else begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = mem_addr_q + 12'd1;
                    mem_wd_d   = CH_SPACE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (adv_row) begin
            if (cur_y_q == LAST_Y) begin
                cur_y_d    = '0;
                row_base_d = '0;
            end else begin
                cur_y_d    = cur_y_q + 5'd1;
                row_base_d = row_base_q + ROW_STEP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cur_x_q    <= '0;
            cur_y_q    <= '0;
            row_base_q <= '0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_wd_q   <= '0;
        end else begin
            state_q    <= state_d;
            cur_x_q    <= cur_x_d;
            cur_y_q    <= cur_y_d;
            row_base_q <= row_base_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_wd_q   <= mem_wd_d;
        end
    end

    assign busy     = (state_q == CLEAR);
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_wd   = mem_wd_q;
    assign cur_x    = cur_x_q;
    assign cur_y    = cur_y_q;

endmodule

// File: tb/tb_display_writer.sv
// Directed self-checking bench for display_writer with hand-computed expectations.
module tb_display_writer;

    logic        clk;
    logic        rst;
    logic [7:0]  char_in;
    logic        char_vld;
    logic        char_rdy;
    logic        clr_req;
    logic        busy;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wd;
    logic [6:0]  cur_x;
    logic [4:0]  cur_y;

    int unsigned total = 0;
    int unsigned bad   = 0;

    display_writer #(.COLS(80), .ROWS(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .char_in  (char_in),
        .char_vld (char_vld),
        .char_rdy (char_rdy),
        .clr_req  (clr_req),
        .busy     (busy),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wd   (mem_wd),
        .cur_x    (cur_x),
        .cur_y    (cur_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] c);
        char_in  = c;
        char_vld = 1'b1;
        tick();
        char_vld = 1'b0;
    endtask

    task automatic chk_cur(input string tag, input int unsigned x, input int unsigned y);
        check({tag, "_x"}, 32'(cur_x), 32'(x));
        check({tag, "_y"}, 32'(cur_y), 32'(y));
    endtask

    initial begin
        int unsigned n_wr;
        int unsigned n_err;
        int unsigned cyc;

        rst      = 1'b1;
        clr_req  = 1'b0;
        char_vld = 1'b1;
        char_in  = 8'h5A;
        tick();
        tick();
        check("rst_we",   32'(mem_we), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wd",   32'(mem_wd), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        chk_cur("rst", 0, 0);
        rst      = 1'b0;
        char_vld = 1'b0;
        #1;
        check("rdy_after_rst", 32'(char_rdy), 32'd1);

        // First character lands at address 0.
        send(8'h41);
        check("a_we",   32'(mem_we), 32'd1);
        check("a_addr", 32'(mem_addr), 32'd0);
        check("a_wd",   32'(mem_wd), 32'h41);
        chk_cur("a", 1, 0);

        // Back-to-back fill to column 79, then wrap into row 1.
        send(8'h0D);
        check("cr_we", 32'(mem_we), 32'd0);
        chk_cur("cr", 0, 0);
        n_wr = 0;
        for (int i = 0; i < 79; i++) begin
            char_in  = 8'h2E;
            char_vld = 1'b1;
            tick();
            if (mem_we === 1'b1 && mem_addr === 12'(i)) n_wr++;
        end
        char_vld = 1'b0;
        check("fill_writes", n_wr, 32'd79);
        chk_cur("fill", 79, 0);
        send(8'h42);
        check("b_we",   32'(mem_we), 32'd1);
        check("b_addr", 32'(mem_addr), 32'd79);
        check("b_wd",   32'(mem_wd), 32'h42);
        chk_cur("b", 0, 1);
        send(8'h43);
        check("c_addr", 32'(mem_addr), 32'd80);
        check("c_wd",   32'(mem_wd), 32'h43);
        chk_cur("c", 1, 1);

        // Walk to (5,31), then LF wraps the row back to 0.
        for (int i = 0; i < 30; i++) send(8'h0A);
        chk_cur("lf30", 0, 31);
        for (int i = 0; i < 5; i++) send(8'h7E);
        check("r31_addr", 32'(mem_addr), 32'd2484);
        check("r31_wd",   32'(mem_wd), 32'h7E);
        chk_cur("r31", 5, 31);
        send(8'h0A);
        check("lfwrap_we", 32'(mem_we), 32'd0);
        chk_cur("lfwrap", 0, 0);
        send(8'h0D);
        check("cr0_we", 32'(mem_we), 32'd0);
        chk_cur("cr0", 0, 0);
        send(8'h08);
        check("bs0_we", 32'(mem_we), 32'd0);
        chk_cur("bs0", 0, 0);

        // Backspace from a nonzero column, then non-printable codes are no-ops.
        send(8'h20);
        check("sp_wd", 32'(mem_wd), 32'h20);
        send(8'h61);
        check("lo_addr", 32'(mem_addr), 32'd1);
        send(8'h08);
        check("bs_we", 32'(mem_we), 32'd0);
        chk_cur("bs", 1, 0);
        send(8'h7F);
        check("del_we", 32'(mem_we), 32'd0);
        chk_cur("del", 1, 0);
        send(8'h1F);
        check("us_we", 32'(mem_we), 32'd0);
        chk_cur("us", 1, 0);

        // Clear beats a simultaneous character; the held 'A' follows the sweep.
        clr_req  = 1'b1;
        char_in  = 8'h41;
        char_vld = 1'b1;
        #1;
        check("clr_rdy", 32'(char_rdy), 32'd0);
        tick();
        clr_req = 1'b0;
        check("clr_busy", 32'(busy), 32'd1);
        cyc   = 0;
        n_err = 0;
        while (busy === 1'b1 && cyc < 3000) begin
            if (mem_we !== 1'b1 || mem_addr !== 12'(cyc) || mem_wd !== 8'h20 || char_rdy !== 1'b0)
                n_err++;
            clr_req = (cyc == 100);
            tick();
            cyc++;
        end
        clr_req = 1'b0;
        check("sweep_cycles", cyc, 32'd2560);
        check("sweep_errs", n_err, 32'd0);
        check("post_we",  32'(mem_we), 32'd0);
        check("post_rdy", 32'(char_rdy), 32'd1);
        chk_cur("post", 0, 0);
        tick();
        char_vld = 1'b0;
        check("held_we",   32'(mem_we), 32'd1);
        check("held_addr", 32'(mem_addr), 32'd0);
        check("held_wd",   32'(mem_wd), 32'h41);
        chk_cur("held", 1, 0);

        // Reset while address 999 is on the bus: 1000 onward never written.
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        cyc  = 0;
        n_wr = 0;
        while (!(mem_we === 1'b1 && mem_addr === 12'd999) && cyc < 3000) begin
            if (mem_we === 1'b1) n_wr++;
            tick();
            cyc++;
        end
        check("abort_reach", 32'(mem_addr), 32'd999);
        n_wr++;
        rst = 1'b1;
        tick();
        check("abort_we",   32'(mem_we), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_writes", n_wr, 32'd1000);
        chk_cur("abort", 0, 0);
        rst = 1'b0;
        tick();
        check("abort_idle_rdy", 32'(char_rdy), 32'd1);
        check("abort_idle_we",  32'(mem_we), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
